encoder_8_3_seq: RTL and testbench

Sequential 8-to-3 priority encoder that works in the opposite direction to the lab's 3-to-8 decoder. It captures an 8-bit request vector and emits the 3-bit index of every set bit, highest index first, one code per valid/ready transfer. Each served bit is cleared, and completion is signalled with a one-cycle `done` pulse. It turns a one-hot or multi-hot line set back into binary codes for a downstream consumer.

---
 rtl/encoder_8_3_seq_if.sv | 31 +++
 rtl/encoder_8_3_seq.sv | 107 ++++++++++
 tb/tb_encoder_8_3_seq.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/encoder_8_3_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : encoder_8_3_seq_if
// Purpose  : Bundles the control, request and code/handshake signals of
//            encoder_8_3_seq.
//   master : drives en, load, D, ready; observes code, valid, busy, done, count
//   slave  : the encoder itself (mirror of master)
// Revision : 1.0  initial release
// ============================================================================
interface encoder_8_3_seq_if;
  logic       en;
  logic       load;
  logic [7:0] D;
  logic       ready;
  logic [2:0] code;
  logic       valid;
  logic       busy;
  logic       done;
  logic [3:0] count;

  modport master (
    output en, load, D, ready,
    input  code, valid, busy, done, count
  );

  modport slave (
    input  en, load, D, ready,
    output code, valid, busy, done, count
  );
endinterface
`default_nettype wire

// File: rtl/encoder_8_3_seq.sv
`default_nettype none
// ============================================================================
// Module   : encoder_8_3_seq
// Purpose  : Sequential 8-to-3 priority encoder. Captures an 8-bit request
//            vector and emits the index of every set bit, highest first, one
//            code per valid/ready transfer, then pulses done for one cycle.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            bus    - encoder_8_3_seq_if.slave
//                     en/load/D/ready in; code/valid/busy/done/count out
// Revision : 1.0  initial release
// ============================================================================
module encoder_8_3_seq (
  input  wire logic          clk,
  input  wire logic          rst_n,
  encoder_8_3_seq_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] pending;
  logic [7:0] pending_next;
  logic [3:0] count_q;
  logic [3:0] count_next;
  logic       done_q;
  logic       done_next;
  logic [2:0] top_idx;
  logic       in_busy;
  logic       xfer;

  // Index of the most significant pending bit. Ascending scan so the last
  // (highest) set bit found wins.
  always_comb begin
    top_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pending[i]) begin
        top_idx = i[2:0];
      end
    end
  end

  assign in_busy = (state == BUSY);
  assign xfer    = in_busy && bus.en && bus.ready;

  always_comb begin
    state_next   = state;
    pending_next = pending;
    count_next   = count_q;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.en && bus.load) begin
          pending_next = bus.D;
          count_next   = 4'd0;
          // An empty request vector completes immediately as a zero-length batch.
          if (bus.D == 8'd0) begin
            done_next = 1'b1;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (xfer) begin
          pending_next[top_idx] = 1'b0;
          count_next            = count_q + 4'd1;
          if (pending_next == 8'd0) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= 8'd0;
      count_q <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      count_q <= count_next;
      done_q  <= done_next;
    end
  end

  // en gates valid directly so a pause takes effect in the same cycle;
  // code is forced to 0 whenever it is not meaningful.
  assign bus.busy  = in_busy;
  assign bus.valid = in_busy && bus.en;
  assign bus.code  = (in_busy && bus.en) ? top_idx : 3'd0;
  assign bus.done  = done_q;
  assign bus.count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_encoder_8_3_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_encoder_8_3_seq
// Purpose  : Self-checking bench for encoder_8_3_seq. A queue-based model
//            holds the codes still owed for the current batch.
// Revision : 1.0  initial release
// ============================================================================
module tb_encoder_8_3_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  encoder_8_3_seq_if bus();

  encoder_8_3_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: codes still to be emitted, highest index first.
  int m_q[$];
  bit m_busy  = 1'b0;
  bit m_done  = 1'b0;
  int m_count = 0;

  function automatic logic [9:0] snap();
    return {bus.valid, bus.code, bus.busy, bus.done, bus.count};
  endfunction

  function automatic logic [9:0] expect_now();
    logic       v;
    logic [2:0] c;
    v = m_busy && bus.en;
    c = v ? 3'(m_q[0]) : 3'd0;
    return {v, c, m_busy, m_done, 4'(m_count)};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_busy  = 1'b0;
    m_done  = 1'b0;
    m_count = 0;
  endtask

  // Called right after a rising edge; inputs are still the values sampled there.
  task automatic model_edge();
    m_done = 1'b0;
    if (!m_busy) begin
      if (bus.en && bus.load) begin
        m_count = 0;
        m_q.delete();
        for (int i = 7; i >= 0; i--) if (bus.D[i]) m_q.push_back(i);
        if (m_q.size() == 0) m_done = 1'b1;
        else                 m_busy = 1'b1;
      end
    end else if (bus.en && bus.ready) begin
      void'(m_q.pop_front());
      m_count++;
      if (m_q.size() == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic drive(input bit e, input bit l, input logic [7:0] d, input bit r);
    bus.en    = e;
    bus.load  = l;
    bus.D     = d;
    bus.ready = r;
  endtask

  task automatic test_reset();
    drive(0, 0, 8'h00, 0);
    rst_n = 1'b0;
    model_reset();
    #3;
    n_checks++;
    if (snap() !== 10'd0) begin
      n_errors++;
      $display("FAIL reset_asserted: got %b required %b", snap(), 10'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (snap() !== 10'd0) begin
      n_errors++;
      $display("FAIL reset_released: got %b required %b", snap(), 10'd0);
    end
  endtask

  task automatic test_basic();
    int seen[$];
    int dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) drive(1, 1, 8'hA4, 1);
      else        drive(1, 0, 8'h00, 1);
      @(negedge clk);
      n_checks++;
      if (snap() !== expect_now()) begin
        n_errors++;
        $display("FAIL basic cyc%0d: got %b required %b", i, snap(), expect_now());
      end
      if (bus.valid) seen.push_back(int'(bus.code));
      if (bus.done)  dones++;
      @(posedge clk); model_edge(); #1;
    end
    n_checks++;
    if (seen.size() != 3 || seen[0] != 7 || seen[1] != 5 || seen[2] != 2) begin
      n_errors++;
      $display("FAIL basic_codes: got %p required '{7,5,2}", seen);
    end
    n_checks++;
    if (dones != 1) begin
      n_errors++;
      $display("FAIL basic_done_pulses: got %0d required 1", dones);
    end
    n_checks++;
    if (bus.count !== 4'd3 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_final: got count=%0d busy=%b required count=3 busy=0", bus.count, bus.busy);
    end
  endtask

  task automatic test_backpressure();
    int held7 = 0;
    int seen[$];
    for (int i = 0; i < 8; i++) begin
      drive(1, i == 0, (i == 0) ? 8'h81 : 8'h00, i >= 4);
      @(negedge clk);
      n_checks++;
      if (snap() !== expect_now()) begin
        n_errors++;
        $display("FAIL backpressure cyc%0d: got %b required %b", i, snap(), expect_now());
      end
      if (bus.valid && !bus.ready && bus.code == 3'd7) held7++;
      if (bus.valid && bus.ready) seen.push_back(int'(bus.code));
      @(posedge clk); model_edge(); #1;
    end
    n_checks++;
    if (held7 != 3 || seen.size() != 2 || seen[0] != 7 || seen[1] != 0) begin
      n_errors++;
      $display("FAIL backpressure_seq: got held=%0d xfers=%p required held=3 xfers='{7,0}", held7, seen);
    end
    n_checks++;
    if (bus.count !== 4'd2) begin
      n_errors++;
      $display("FAIL backpressure_count: got %0d required 2", bus.count);
    end
  endtask

  task automatic test_zero();
    int dones = 0;
    int valids = 0;
    int done_cyc = -1;
    for (int i = 0; i < 4; i++) begin
      drive(1, i == 0, 8'h00, 1);
      @(negedge clk);
      n_checks++;
      if (snap() !== expect_now()) begin
        n_errors++;
        $display("FAIL zero cyc%0d: got %b required %b", i, snap(), expect_now());
      end
      if (bus.valid) valids++;
      if (bus.done) begin dones++; done_cyc = i; end
      @(posedge clk); model_edge(); #1;
    end
    n_checks++;
    if (valids != 0 || dones != 1 || done_cyc != 1 || bus.count !== 4'd0) begin
      n_errors++;
      $display("FAIL zero_batch: got valids=%0d dones=%0d at=%0d count=%0d required 0 1 1 0",
               valids, dones, done_cyc, bus.count);
    end
  endtask

  task automatic test_pause();
    int seen[$];
    int valid_paused = 0;
    bit e;
    bit l;
    for (int i = 0; i < 14; i++) begin
      e = !(i == 3 || i == 4);
      l = (i == 0) || (i >= 2 && i <= 4);
      drive(e, l, (i == 0) ? 8'hFF : 8'h01, 1);
      @(negedge clk);
      n_checks++;
      if (snap() !== expect_now()) begin
        n_errors++;
        $display("FAIL pause cyc%0d: got %b required %b", i, snap(), expect_now());
      end
      if (!e && bus.valid) valid_paused++;
      if (bus.valid && bus.ready) seen.push_back(int'(bus.code));
      @(posedge clk); model_edge(); #1;
    end
    n_checks++;
    if (seen != '{7, 6, 5, 4, 3, 2, 1, 0} || valid_paused != 0) begin
      n_errors++;
      $display("FAIL pause_codes: got %p paused_valid=%0d required '{7..0} 0", seen, valid_paused);
    end
    n_checks++;
    if (bus.count !== 4'd8) begin
      n_errors++;
      $display("FAIL pause_count: got %0d required 8", bus.count);
    end
  endtask

  task automatic test_reset_mid();
    int seen[$];
    int dones = 0;
    for (int i = 0; i < 2; i++) begin
      drive(1, i == 0, 8'h70, 1);
      @(negedge clk);
      n_checks++;
      if (snap() !== expect_now()) begin
        n_errors++;
        $display("FAIL rstmid cyc%0d: got %b required %b", i, snap(), expect_now());
      end
      @(posedge clk); model_edge(); #1;
    end
    drive(1, 0, 8'h00, 1);
    @(negedge clk);
    n_checks++;
    if (snap() !== {1'b1, 3'd5, 1'b1, 1'b0, 4'd1}) begin
      n_errors++;
      $display("FAIL rstmid_before: got %b required %b", snap(), {1'b1, 3'd5, 1'b1, 1'b0, 4'd1});
    end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (snap() !== 10'd0) begin
      n_errors++;
      $display("FAIL rstmid_abort: got %b required %b", snap(), 10'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      drive(1, i == 0, 8'h02, 1);
      @(negedge clk);
      n_checks++;
      if (snap() !== expect_now()) begin
        n_errors++;
        $display("FAIL rstmid_reload cyc%0d: got %b required %b", i, snap(), expect_now());
      end
      if (bus.valid) seen.push_back(int'(bus.code));
      if (bus.done)  dones++;
      @(posedge clk); model_edge(); #1;
    end
    n_checks++;
    if (seen != '{1} || dones != 1 || bus.count !== 4'd1) begin
      n_errors++;
      $display("FAIL rstmid_reload: got codes=%p dones=%0d count=%0d required '{1} 1 1", seen, dones, bus.count);
    end
  endtask

  task automatic test_random();
    bit         e;
    bit         l;
    bit         r;
    logic [7:0] d;
    for (int i = 0; i < 600; i++) begin
      e = ($urandom_range(0, 9) < 8);
      l = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 9) < 7);
      d = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      drive(e, l, d, r);
      @(negedge clk);
      n_checks++;
      if (snap() !== expect_now()) begin
        n_errors++;
        $display("FAIL random cyc%0d: got %b required %b", i, snap(), expect_now());
      end
      @(posedge clk); model_edge(); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_pause();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
